bin_to_bcd_seq: RTL



---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin_to_bcd_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;

  localparam int BCD_DIGITS = 4;
  localparam int BCD_MAX    = 9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction: add 3 when the digit is 5 or more
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t nib,
  output bcd_digit_t fix
);

  assign fix = (nib >= 4'd5) ? bcd_digit_t'(nib + 4'd3) : nib;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 converter feeding the 4-digit display
// Optional macro BCD_OVF_HEX_EN: show overflowed inputs as raw hex instead of saturating to 9999.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = BCD_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output bcd_digit_t       dig0,
  output bcd_digit_t       dig1,
  output bcd_digit_t       dig2,
  output bcd_digit_t       dig3
);

  localparam int SW = 16 + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  bcd_state_t    state, state_nxt;
  logic [SW-1:0] sreg, sreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ovf_path, ovf_path_nxt;
  logic          settle, settle_nxt;
  logic          load;
  logic          over;
  logic [15:0]   bcd_corr;
  logic [SW-1:0] shifted;
  logic [15:0]   result;

  // BCD field sits above the binary field; each nibble is corrected before the shift
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib (sreg[WIDTH + 4*g +: 4]),
      .fix (bcd_corr[4*g +: 4])
    );
  end

  assign shifted = {bcd_corr, sreg[WIDTH-1:0]} << 1;
  assign over    = ($unsigned(32'(bin)) > $unsigned(32'(MAX_VAL)));
  assign busy    = (state == SHIFT);

  always_comb begin
    result = sreg[SW-1:WIDTH];
    if (ovf_path) begin
`ifdef BCD_OVF_HEX_EN
      result = 16'(sreg[WIDTH-1:0]);
`else
      result = 16'h9999;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    sreg_nxt     = sreg;
    cnt_nxt      = cnt;
    ovf_path_nxt = ovf_path;
    settle_nxt   = settle;
    load         = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          sreg_nxt     = {16'h0000, bin};
          cnt_nxt      = '0;
          ovf_path_nxt = over;
          settle_nxt   = over;
          state_nxt    = over ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sreg_nxt = shifted;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        // overflow results linger one extra cycle so their latency is a fixed two edges
        if (settle) begin
          settle_nxt = 1'b0;
        end else begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sreg     <= '0;
      cnt      <= '0;
      ovf_path <= 1'b0;
      settle   <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      dig0     <= '0;
      dig1     <= '0;
      dig2     <= '0;
      dig3     <= '0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      cnt      <= cnt_nxt;
      ovf_path <= ovf_path_nxt;
      settle   <= settle_nxt;
      done     <= load;
      if (load) begin
        dig0 <= result[3:0];
        dig1 <= result[7:4];
        dig2 <= result[11:8];
        dig3 <= result[15:12];
        ovf  <= ovf_path;
      end
    end
  end

endmodule
